vfr_read_sequencer: RTL and testbench
=====================================

Name: vfr_read_sequencer

Overview:
- Frame-level controller that sequences the memory-to-pixel read path of the frame reader.
- Issues Avalon-MM burst reads for one frame and limits outstanding words to the read FIFO depth (credit scheme).
- Counts words consumed and samples produced by the unpacker.
- Pulses the unpacker's clear at end of frame so residual bits never leak into the next frame.

Parameters:
- ADDR_WIDTH, 32, byte address width of the memory master
- DATA_WIDTH_IN, 128, memory word width in bits; the address increment per word is DATA_WIDTH_IN/8
- BURST_LEN, 8, maximum words per burst; power of two, 1..64
- MAX_OUTSTANDING, 32, read FIFO depth in words; must be >= BURST_LEN
- COUNT_WIDTH, 24, width of the frame word and sample counters

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- go  in  1  start a frame; sampled in IDLE only
- base_addr  in  ADDR_WIDTH  frame start byte address; word-aligned
- frame_words  in  COUNT_WIDTH  memory words to fetch; 0 is illegal
- frame_samples  in  COUNT_WIDTH  samples the unpacker must emit
- busy  out  1  high from go acceptance until done
- done  out  1  one-cycle pulse when the frame completes
- av_address  out  ADDR_WIDTH  burst start address
- av_read  out  1  read request
- av_burstcount  out  7  words in this burst
- av_waitrequest  in  1  slave stall
- av_readdatavalid  in  1  one returned word
- word_pop  in  1  unpacker consumed one FIFO word (read & ~stall_in)
- sample_push  in  1  unpacker emitted one sample (write & ~stall_out)
- clear  out  1  discard pulse to the unpacker

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- IDLE:
  - busy=0.
  - On go: latch base_addr, frame_words and frame_samples; set words_left=frame_words; zero rx_cnt, samp_cnt and outstanding; busy=1 next cycle; go to REQ.
- REQ:
  - A burst is allowed when words_left>0 and outstanding + min(BURST_LEN, words_left) <= MAX_OUTSTANDING.
  - When allowed, drive av_read=1, av_address=cur_addr, av_burstcount=min(BURST_LEN, words_left).
  - Hold address, read and burstcount stable while av_waitrequest=1.
  - On acceptance (av_read & ~av_waitrequest):
    - words_left -= burstcount
    - cur_addr += burstcount*DATA_WIDTH_IN/8
    - outstanding += burstcount
  - The next burst may issue the following cycle.
  - When words_left reaches 0, go to DRAIN.
- Outstanding counter:
  - Decrements by 1 per word_pop.
  - Acceptance and word_pop in the same cycle apply both updates (net +burstcount-1).
  - Width is clog2(MAX_OUTSTANDING)+1.
- rx_cnt increments on av_readdatavalid in any non-IDLE state.
- samp_cnt increments on sample_push and saturates at frame_samples.
- DRAIN: wait until rx_cnt==frame_words and samp_cnt==frame_samples, then go to FLUSH.
- FLUSH:
  - clear=1 for exactly one cycle; unconsumed FIFO words are counted as discarded.
  - Next state DONE.
- DONE:
  - done=1 for one cycle, busy=0 that same cycle.
  - Return to IDLE. A go asserted during DONE is ignored; the requester must re-assert it in IDLE.
- Latency: go to first av_read is 1 cycle. Last qualifying sample_push to clear is 2 cycles (DRAIN compare registered). clear to done is 1 cycle.
- go while busy is ignored.
- A sample_push beyond frame_samples does not wrap the counter.
- av_readdatavalid with no outstanding request is a protocol error. It is not checked in RTL; the bench asserts on it.
- Reset mid-frame returns to IDLE immediately and drops av_read asynchronously. The memory slave is reset in the same domain.

Decomposition:
- Shared package holds:
  - state enum (IDLE, REQ, DRAIN, FLUSH, DONE)
  - burstcount width constant (7)
  - function min_burst(words_left) returning the clipped burst length
- Natural sub-module: vfr_read_credit_counter, owning the outstanding-word counter and the "burst allowed" compare. Inputs: accept, burstcount, word_pop. Output: allowed.

Test Plan:
- frame_words=20, BURST_LEN=8, no waitrequest, consumer never stalls -> bursts at base, base+0x80 (8 words), then base+0x100 with 4 words; exactly 3 av_read acceptances.
- MAX_OUTSTANDING=16, word_pop held low -> exactly 2 bursts of 8 issued, av_read stays 0; first word_pop -> third burst issues only after outstanding <= 8.
- av_waitrequest high 5 cycles on the first burst -> address and burstcount are stable across all 5 cycles; only one burst is counted.
- frame_samples=100, 100th sample_push arrives after the last readdatavalid -> clear high 2 cycles later for 1 cycle, done 1 cycle after clear, busy falls together with done.
- Same-cycle burst acceptance (8) and word_pop with outstanding=10 -> outstanding=17 next cycle.
- reset_n asserted in REQ with a burst pending -> av_read=0, busy=0, clear=0 immediately; after release, go starts a fresh frame from base_addr.

Source files
------------

// File: rtl/vfr_read_sequencer_pkg.sv
// Shared types and helpers for the frame reader read-path sequencer.
// Holds the FSM state encoding, the Avalon burstcount width and burst clipping.
package vfr_read_sequencer_pkg;

    localparam int unsigned BC_WIDTH = 7;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    // Length of the next burst: BURST_LEN, or fewer words at the frame tail.
    function automatic logic [BC_WIDTH-1:0] min_burst(input logic [31:0] words_left,
                                                      input int unsigned burst_len);
        logic [31:0] len;
        len = (words_left < burst_len) ? words_left : burst_len;
        return len[BC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/vfr_read_credit_counter.sv
// Tracks words requested but not yet consumed from the read FIFO and decides
// whether a burst of next_len words still fits in the FIFO.
module vfr_read_credit_counter
    import vfr_read_sequencer_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                accept,
    input  logic [BC_WIDTH-1:0] burstcount,
    input  logic                word_pop,
    input  logic [BC_WIDTH-1:0] next_len,
    output logic                allowed
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SW = OW + BC_WIDTH;

    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] outstanding_d;
    logic [SW-1:0] demand;

    // allowed looks at the post-update count so a burst can follow an
    // acceptance or a pop in the very next cycle.
    always_comb begin
        outstanding_d = outstanding_q;
        if (clr) begin
            outstanding_d = '0;
        end else begin
            if (accept) begin
                outstanding_d = outstanding_d + OW'(burstcount);
            end
            if (word_pop && (outstanding_q != '0)) begin
                outstanding_d = outstanding_d - OW'(1);
            end
        end
        demand  = SW'(outstanding_d) + SW'(next_len);
        allowed = (demand <= SW'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

endmodule

// File: rtl/vfr_read_sequencer.sv
// Frame-level sequencer for the memory-to-pixel read path: issues credit-limited
// Avalon-MM burst reads, tracks returned words and produced samples, clears the unpacker.
module vfr_read_sequencer
    import vfr_read_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH_IN   = 128,
    parameter int unsigned BURST_LEN       = 8,
    parameter int unsigned MAX_OUTSTANDING = 32,
    parameter int unsigned COUNT_WIDTH     = 24
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   go,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] frame_words,
    input  logic [COUNT_WIDTH-1:0] frame_samples,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  av_address,
    output logic                   av_read,
    output logic [BC_WIDTH-1:0]    av_burstcount,
    input  logic                   av_waitrequest,
    input  logic                   av_readdatavalid,
    input  logic                   word_pop,
    input  logic                   sample_push,
    output logic                   clear
);

    localparam int unsigned BYTES_PER_WORD = DATA_WIDTH_IN / 8;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   clear_q, clear_d;
    logic                   av_read_q, av_read_d;
    logic [ADDR_WIDTH-1:0]  av_address_q, av_address_d;
    logic [BC_WIDTH-1:0]    av_burstcount_q, av_burstcount_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [COUNT_WIDTH-1:0] words_left_q, words_left_d;
    logic [COUNT_WIDTH-1:0] frame_words_q, frame_words_d;
    logic [COUNT_WIDTH-1:0] frame_samples_q, frame_samples_d;
    logic [COUNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d;
    logic [COUNT_WIDTH-1:0] samp_cnt_q, samp_cnt_d;
    logic                   drain_ok_q, drain_ok_d;

    logic                   accept;
    logic                   credit_clr;
    logic                   allowed;
    logic [COUNT_WIDTH-1:0] words_left_nx;
    logic [BC_WIDTH-1:0]    next_len;

    assign accept        = (state_q == REQ) && av_read_q && !av_waitrequest;
    assign words_left_nx = accept ? (words_left_q - COUNT_WIDTH'(av_burstcount_q)) : words_left_q;
    assign next_len      = (state_q == IDLE) ? min_burst(32'(frame_words), BURST_LEN)
                                             : min_burst(32'(words_left_nx), BURST_LEN);
    // Credits restart at go and are released at flush: unconsumed words are discarded.
    assign credit_clr    = (state_q == IDLE) || (state_q == FLUSH);

    vfr_read_credit_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr        (credit_clr),
        .accept     (accept),
        .burstcount (av_burstcount_q),
        .word_pop   (word_pop),
        .next_len   (next_len),
        .allowed    (allowed)
    );

    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        clear_d         = 1'b0;
        av_read_d       = av_read_q;
        av_address_d    = av_address_q;
        av_burstcount_d = av_burstcount_q;
        cur_addr_d      = cur_addr_q;
        words_left_d    = words_left_q;
        frame_words_d   = frame_words_q;
        frame_samples_d = frame_samples_q;
        rx_cnt_d        = rx_cnt_q;
        samp_cnt_d      = samp_cnt_q;

        if ((state_q != IDLE) && av_readdatavalid) begin
            rx_cnt_d = rx_cnt_q + COUNT_WIDTH'(1);
        end
        if ((state_q != IDLE) && sample_push && (samp_cnt_q != frame_samples_q)) begin
            samp_cnt_d = samp_cnt_q + COUNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (go) begin
                    frame_words_d   = frame_words;
                    frame_samples_d = frame_samples;
                    words_left_d    = frame_words;
                    cur_addr_d      = base_addr;
                    rx_cnt_d        = '0;
                    samp_cnt_d      = '0;
                    av_read_d       = (frame_words != '0);
                    av_address_d    = base_addr;
                    av_burstcount_d = next_len;
                    busy_d          = 1'b1;
                    state_d         = REQ;
                end
            end
            REQ: begin
                if (!(av_read_q && av_waitrequest)) begin
                    words_left_d = words_left_nx;
                    if (accept) begin
                        cur_addr_d = cur_addr_q
                                   + ADDR_WIDTH'(av_burstcount_q) * ADDR_WIDTH'(BYTES_PER_WORD);
                    end
                    av_read_d = (words_left_nx != '0) && allowed;
                    if (av_read_d) begin
                        av_address_d    = cur_addr_d;
                        av_burstcount_d = next_len;
                    end
                    if (words_left_nx == '0) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_ok_q) begin
                    clear_d = 1'b1;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Compared on next-state counts so the decision is ready one cycle after the last event.
        drain_ok_d = (state_q != IDLE)
                  && (rx_cnt_d == frame_words_q)
                  && (samp_cnt_d == frame_samples_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            clear_q         <= 1'b0;
            av_read_q       <= 1'b0;
            av_address_q    <= '0;
            av_burstcount_q <= '0;
            cur_addr_q      <= '0;
            words_left_q    <= '0;
            frame_words_q   <= '0;
            frame_samples_q <= '0;
            rx_cnt_q        <= '0;
            samp_cnt_q      <= '0;
            drain_ok_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            clear_q         <= clear_d;
            av_read_q       <= av_read_d;
            av_address_q    <= av_address_d;
            av_burstcount_q <= av_burstcount_d;
            cur_addr_q      <= cur_addr_d;
            words_left_q    <= words_left_d;
            frame_words_q   <= frame_words_d;
            frame_samples_q <= frame_samples_d;
            rx_cnt_q        <= rx_cnt_d;
            samp_cnt_q      <= samp_cnt_d;
            drain_ok_q      <= drain_ok_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign clear         = clear_q;
    assign av_read       = av_read_q;
    assign av_address    = av_address_q;
    assign av_burstcount = av_burstcount_q;

endmodule

// File: tb/tb_vfr_read_sequencer.sv
// Scoreboard bench for vfr_read_sequencer: expected bursts and frame completions
// are queued by the stimulus and consumed by a negedge monitor.
module tb_vfr_read_sequencer;
    import vfr_read_sequencer_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned BL = 8;
    localparam int unsigned MO = 16;
    localparam int unsigned CW = 24;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] frame_words = '0;
    logic [CW-1:0] frame_samples = '0;
    logic          busy, done, av_read, clear;
    logic [AW-1:0] av_address;
    logic [BC_WIDTH-1:0] av_burstcount;
    logic          av_waitrequest = 1'b0;
    logic          av_readdatavalid = 1'b0;
    logic          word_pop = 1'b0;
    logic          sample_push = 1'b0;

    logic                cc_clr = 1'b0, cc_accept = 1'b0, cc_pop = 1'b0, cc_allowed;
    logic [BC_WIDTH-1:0] cc_bc = '0, cc_len = '0;

    always #5 clock = ~clock;

    vfr_read_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH_IN(DW), .BURST_LEN(BL),
        .MAX_OUTSTANDING(MO), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .go(go), .base_addr(base_addr),
        .frame_words(frame_words), .frame_samples(frame_samples),
        .busy(busy), .done(done), .av_address(av_address), .av_read(av_read),
        .av_burstcount(av_burstcount), .av_waitrequest(av_waitrequest),
        .av_readdatavalid(av_readdatavalid), .word_pop(word_pop),
        .sample_push(sample_push), .clear(clear)
    );

    vfr_read_credit_counter #(.MAX_OUTSTANDING(32)) u_cc (
        .clock(clock), .reset_n(reset_n), .clr(cc_clr), .accept(cc_accept),
        .burstcount(cc_bc), .word_pop(cc_pop), .next_len(cc_len), .allowed(cc_allowed)
    );

    typedef struct {
        logic [AW-1:0]       addr;
        logic [BC_WIDTH-1:0] bc;
    } burst_t;

    burst_t exp_bursts[$];
    int     exp_done[$];

    int checks = 0;
    int errors = 0;

    // slave / consumer model state
    int pend = 0, fifo = 0, stall_cnt = 0;
    bit pop_en = 1'b0;

    // monitor state
    int            mout = 0, acc_count = 0, stall_run = 0, last_stall = 0, last_acc_out = -1;
    bit            prev_stall = 1'b0, prev_clear = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [BC_WIDTH-1:0] hold_bc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input logic [AW-1:0] addr, input int bc);
        burst_t b;
        b.addr = addr;
        b.bc   = BC_WIDTH'(bc);
        exp_bursts.push_back(b);
    endtask

    // Avalon slave returning one word per cycle, plus a FIFO consumer
    initial begin
        bit acc, rdv_now, pop_now;
        int bc;
        forever begin
            @(negedge clock);
            acc     = av_read && !av_waitrequest;
            bc      = int'(av_burstcount);
            rdv_now = av_readdatavalid;
            pop_now = word_pop;
            @(posedge clock);
            #1;
            if (!reset_n) begin
                pend = 0;
                fifo = 0;
            end else begin
                if (acc) pend += bc;
                if (rdv_now) begin pend--; fifo++; end
                if (pop_now) fifo--;
            end
            av_readdatavalid = reset_n && (pend > 0);
            word_pop         = reset_n && pop_en && (fifo > 0);
            if (reset_n && av_read && stall_cnt > 0) begin
                av_waitrequest = 1'b1;
                stall_cnt--;
            end else begin
                av_waitrequest = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        int mnext;
        burst_t eb;
        int n;
        if (!reset_n) begin
            mout = 0; acc_count = 0; stall_run = 0; prev_stall = 1'b0; prev_clear = 1'b0;
        end else begin
            assert (!(av_readdatavalid && pend == 0)) else begin
                errors++;
                $display("FAIL protocol readdatavalid with nothing outstanding");
            end
            mnext = mout;
            if (av_read && av_waitrequest) begin
                if (prev_stall) begin
                    check("stall_addr", av_address, hold_addr);
                    check("stall_bc", av_burstcount, hold_bc);
                end
                hold_addr  = av_address;
                hold_bc    = av_burstcount;
                prev_stall = 1'b1;
                stall_run++;
            end else if (av_read) begin
                if (exp_bursts.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL burst_unexpected actual=%0h/%0d expected=none", av_address, av_burstcount);
                end else begin
                    eb = exp_bursts.pop_front();
                    check("burst_addr", av_address, eb.addr);
                    check("burst_bc", av_burstcount, eb.bc);
                end
                check("credit_limit", (mout + int'(av_burstcount) <= int'(MO)) ? 1 : 0, 1);
                last_acc_out = mout;
                last_stall   = stall_run;
                stall_run    = 0;
                prev_stall   = 1'b0;
                acc_count++;
                mnext += int'(av_burstcount);
            end else begin
                stall_run  = 0;
                prev_stall = 1'b0;
            end
            if (word_pop && mout > 0) mnext--;
            mout = (clear || !busy) ? 0 : mnext;
            if (done) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 expected=0");
                end else begin
                    n = exp_done.pop_front();
                    check("done_burst_count", acc_count, n);
                    check("done_busy_low", busy, 0);
                    check("clear_before_done", prev_clear, 1);
                end
                acc_count = 0;
            end
            prev_clear = clear;
        end
    end

    task automatic start_frame(input logic [AW-1:0] base, input int words, input int samples);
        @(posedge clock);
        #1;
        go            = 1'b1;
        base_addr     = base;
        frame_words   = CW'(words);
        frame_samples = CW'(samples);
        @(posedge clock);
        #1;
        go = 1'b0;
        check("go_av_read", av_read, 1);
        check("go_busy", busy, 1);
        check("go_address", av_address, base);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < budget);
        check({name, "_done_seen"}, done, 1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_av_read", av_read, 0);
        check("rst_av_address", av_address, 0);
        check("rst_av_burstcount", av_burstcount, 0);
        check("rst_clear", clear, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // 20 words: 8 + 8 + 4, with an ignored go while busy
        pop_en = 1'b1;
        expect_burst(32'h0000_1000, 8);
        expect_burst(32'h0000_1080, 8);
        expect_burst(32'h0000_1100, 4);
        exp_done.push_back(3);
        start_frame(32'h0000_1000, 20, 3);
        sample_push = 1'b1;
        go          = 1'b1;
        base_addr   = 32'h0000_F000;
        @(posedge clock);
        #1;
        go = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        sample_push = 1'b0;
        wait_done("frameA", 200);

        // consumer stalled: two bursts fill the 16-word FIFO
        pop_en = 1'b0;
        expect_burst(32'h0000_2000, 8);
        expect_burst(32'h0000_2080, 8);
        expect_burst(32'h0000_2100, 8);
        exp_done.push_back(3);
        start_frame(32'h0000_2000, 24, 0);
        repeat (20) @(negedge clock);
        check("stalled_bursts", acc_count, 2);
        check("stalled_av_read", av_read, 0);
        pop_en = 1'b1;
        wait_done("frameB", 200);
        check("third_burst_outstanding", last_acc_out, 8);

        // waitrequest for 5 cycles on the first burst
        stall_cnt = 5;
        expect_burst(32'h0000_3000, 8);
        exp_done.push_back(1);
        start_frame(32'h0000_3000, 8, 0);
        wait_done("frameC", 200);
        check("stall_cycles", last_stall, 5);

        // 100 samples, last one after all data; one extra push must saturate
        expect_burst(32'h0000_5000, 4);
        exp_done.push_back(1);
        start_frame(32'h0000_5000, 4, 100);
        sample_push = 1'b1;
        repeat (100) @(posedge clock);
        @(negedge clock);
        check("D_clear_plus1", clear, 0);
        check("D_busy_plus1", busy, 1);
        @(posedge clock);
        #1;
        sample_push = 1'b0;
        @(negedge clock);
        check("D_clear_plus2", clear, 1);
        check("D_done_plus2", done, 0);
        check("D_samp_saturated", dut.samp_cnt_q, 100);
        @(negedge clock);
        check("D_done_plus3", done, 1);
        check("D_busy_plus3", busy, 0);
        check("D_clear_plus3", clear, 0);
        go        = 1'b1;
        base_addr = 32'h0000_E000;
        @(posedge clock);
        #1;
        go = 1'b0;
        @(negedge clock);
        check("go_in_done_busy", busy, 0);
        check("go_in_done_av_read", av_read, 0);
        check("D_done_plus4", done, 0);

        // credit counter with a 32-word FIFO
        @(posedge clock);
        #1;
        cc_clr = 1'b1;
        @(posedge clock);
        #1;
        cc_clr = 1'b0;
        check("cc_cleared", u_cc.outstanding_q, 0);
        cc_accept = 1'b1; cc_bc = 7'd10; cc_len = 7'd8;
        @(negedge clock);
        check("cc_allowed_18", cc_allowed, 1);
        @(posedge clock);
        #1;
        check("cc_out_10", u_cc.outstanding_q, 10);
        cc_accept = 1'b1; cc_bc = 7'd8; cc_pop = 1'b1; cc_len = 7'd8;
        @(negedge clock);
        check("cc_allowed_25", cc_allowed, 1);
        @(posedge clock);
        #1;
        check("cc_accept_and_pop", u_cc.outstanding_q, 17);
        cc_accept = 1'b1; cc_bc = 7'd7; cc_pop = 1'b0; cc_len = 7'd8;
        @(negedge clock);
        check("cc_allowed_exact_32", cc_allowed, 1);
        @(posedge clock);
        #1;
        check("cc_out_24", u_cc.outstanding_q, 24);
        cc_accept = 1'b0; cc_len = 7'd9;
        @(negedge clock);
        check("cc_blocked_33", cc_allowed, 0);
        @(posedge clock);
        #1;
        cc_pop = 1'b1;
        @(negedge clock);
        check("cc_pop_frees_credit", cc_allowed, 1);
        @(posedge clock);
        #1;
        cc_pop = 1'b0;
        check("cc_out_23", u_cc.outstanding_q, 23);

        // reset while a burst is held by waitrequest
        stall_cnt = 1000;
        start_frame(32'h0000_6000, 8, 0);
        repeat (3) @(negedge clock);
        check("F_pending_av_read", av_read, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("F_rst_av_read", av_read, 0);
        check("F_rst_busy", busy, 0);
        check("F_rst_clear", clear, 0);
        stall_cnt = 0;
        exp_bursts.delete();
        exp_done.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        expect_burst(32'h0000_7000, 8);
        exp_done.push_back(1);
        start_frame(32'h0000_7000, 8, 0);
        wait_done("frameF", 200);

        repeat (3) @(negedge clock);
        check("bursts_drained", exp_bursts.size(), 0);
        check("frames_drained", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
